// File: rtl/tanimoto_job_ctrl.sv
// Job sequencer in front of tanimoto_top: threshold BRAM load, vector streaming, ID-pair drain.
// Define TANIMOTO_JOB_CTRL_PERF_EN to add the o_JobCycles / o_StallCycles counters.
module tanimoto_job_ctrl #(
   parameter int BUS_WIDTH     = 512,
   parameter int VECTOR_WIDTH  = 920,
   parameter int SUB_VECTOR_NO = 2,
   parameter int REF_VEC_NO    = 8,
   parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH),
   parameter int DRAIN_TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 i_Start,
   input  logic                 i_Abort,
   input  logic [31:0]          i_CmpVecNo,
   input  logic                 i_Thr_Valid,
   input  logic [CNT_WIDTH:0]   i_Thr_Data,
   output logic                 o_Thr_Ready,
   output logic [CNT_WIDTH-1:0] o_BRAM_Addr,
   output logic [CNT_WIDTH:0]   o_BRAM_Din,
   output logic                 o_BRAM_WrEn,
   input  logic                 i_Vec_Valid,
   input  logic [BUS_WIDTH-1:0] i_Vec_Data,
   output logic                 o_Vec_Ready,
   output logic [BUS_WIDTH-1:0] o_Vector,
   output logic                 o_Valid,
   output logic                 o_Last,
   input  logic                 i_Read,
   input  logic                 i_IDPair_Valid,
   input  logic                 i_IDPair_Read,
   input  logic                 i_IDPair_Last,
   output logic                 o_Busy,
   output logic                 o_Done,
   output logic                 o_Timeout,
`ifdef TANIMOTO_JOB_CTRL_PERF_EN
   output logic [31:0]          o_JobCycles,
   output logic [31:0]          o_StallCycles,
`endif
   output logic [31:0]          o_PairCnt
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD_THR = 3'd1,
      S_STREAM   = 3'd2,
      S_DRAIN    = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   localparam int                   IDLE_W      = $clog2(DRAIN_TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] LP_THR_LAST = CNT_WIDTH'(VECTOR_WIDTH - 1);
   localparam logic [IDLE_W-1:0]    LP_IDLE_LIM = IDLE_W'(DRAIN_TIMEOUT - 1);

   state_t                 r_State;
   state_t                 w_NextState;
   logic [CNT_WIDTH-1:0]   r_ThrIdx;
   logic                   r_ThrFull;
   logic [CNT_WIDTH-1:0]   r_BRAM_Addr;
   logic [CNT_WIDTH:0]     r_BRAM_Din;
   logic                   r_BRAM_WrEn;
   logic [31:0]            r_WordCnt;
   logic [31:0]            r_LastIdx;
   logic [31:0]            r_PairCnt;
   logic                   r_Timeout;
   logic                   r_LastSeen;
   logic [IDLE_W-1:0]      r_Idle;

   logic                   w_StartAcc;
   logic                   w_ThrAcc;
   logic                   w_VecFire;
   logic                   w_LastWord;
   logic                   w_PairFire;
   logic                   w_IdleTo;
   logic [31:0]            w_Total;

   assign w_StartAcc = (r_State == S_IDLE) & i_Start & ~i_Abort;
   assign w_ThrAcc   = (r_State == S_LOAD_THR) & ~r_ThrFull & i_Thr_Valid;
   assign w_VecFire  = (r_State == S_STREAM) & i_Vec_Valid & i_Read;
   assign w_LastWord = (r_WordCnt == r_LastIdx);
   assign w_PairFire = ((r_State == S_STREAM) | (r_State == S_DRAIN)) & i_IDPair_Valid & i_IDPair_Read;
   // r_Idle holds the number of cycles since the last pair fire (or DRAIN entry), so DONE
   // lands exactly DRAIN_TIMEOUT cycles after that fire.
   assign w_IdleTo   = (r_Idle == LP_IDLE_LIM) & ~w_PairFire;
   assign w_Total    = (32'(REF_VEC_NO) + i_CmpVecNo) * 32'(SUB_VECTOR_NO);

   assign o_Vector    = i_Vec_Data;
   assign o_BRAM_Addr = r_BRAM_Addr;
   assign o_BRAM_Din  = r_BRAM_Din;
   assign o_BRAM_WrEn = r_BRAM_WrEn;
   assign o_PairCnt   = r_PairCnt;
   assign o_Timeout   = r_Timeout;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_State <= S_IDLE;
      else       r_State <= w_NextState;
   end

   always_comb begin
      w_NextState = r_State;
      if (i_Abort) begin
         w_NextState = S_IDLE;
      end else begin
         case (r_State)
            S_IDLE:     if (i_Start) w_NextState = (i_CmpVecNo == '0) ? S_DONE : S_LOAD_THR;
            S_LOAD_THR: if (r_ThrFull) w_NextState = S_STREAM;
            S_STREAM:   if (w_VecFire & w_LastWord) w_NextState = S_DRAIN;
            S_DRAIN:    if (r_LastSeen | (w_PairFire & i_IDPair_Last) | w_IdleTo) w_NextState = S_DONE;
            S_DONE:     w_NextState = S_IDLE;
            default:    w_NextState = S_IDLE;
         endcase
      end
   end

   always_comb begin
      o_Busy      = (r_State != S_IDLE);
      o_Done      = (r_State == S_DONE) & ~i_Abort;
      o_Thr_Ready = (r_State == S_LOAD_THR) & ~r_ThrFull;
      o_Valid     = (r_State == S_STREAM) & i_Vec_Valid;
      o_Vec_Ready = w_VecFire;
      o_Last      = (r_State == S_STREAM) & i_Vec_Valid & w_LastWord & ~i_Abort;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ThrIdx    <= '0;
         r_ThrFull   <= 1'b0;
         r_BRAM_Addr <= '0;
         r_BRAM_Din  <= '0;
         r_BRAM_WrEn <= 1'b0;
         r_WordCnt   <= '0;
         r_LastIdx   <= '0;
         r_PairCnt   <= '0;
         r_Timeout   <= 1'b0;
         r_LastSeen  <= 1'b0;
         r_Idle      <= '0;
      end else begin
         r_BRAM_WrEn <= w_ThrAcc;
         if (w_StartAcc) begin
            r_ThrIdx   <= '0;
            r_ThrFull  <= 1'b0;
            r_WordCnt  <= '0;
            r_LastIdx  <= w_Total - 32'd1;
            r_PairCnt  <= '0;
            r_Timeout  <= 1'b0;
            r_LastSeen <= 1'b0;
         end
         if (w_ThrAcc) begin
            r_BRAM_Addr <= r_ThrIdx;
            r_BRAM_Din  <= i_Thr_Data;
            r_ThrIdx    <= r_ThrIdx + 1'b1;
            if (r_ThrIdx == LP_THR_LAST) r_ThrFull <= 1'b1;
         end
         if (w_VecFire) r_WordCnt <= r_WordCnt + 32'd1;
         if (w_PairFire && (r_PairCnt != '1)) r_PairCnt <= r_PairCnt + 32'd1;
         if (w_PairFire && i_IDPair_Last) r_LastSeen <= 1'b1;
         if ((r_State != S_DRAIN) || w_PairFire)  r_Idle <= IDLE_W'(1);
         else if (r_Idle != LP_IDLE_LIM)          r_Idle <= r_Idle + 1'b1;
         if ((r_State == S_DRAIN) && !i_Abort && !r_LastSeen && w_IdleTo) r_Timeout <= 1'b1;
      end
   end

`ifdef TANIMOTO_JOB_CTRL_PERF_EN
   logic [31:0] r_JobCycles;
   logic [31:0] r_StallCycles;

   assign o_JobCycles   = r_JobCycles;
   assign o_StallCycles = r_StallCycles;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_JobCycles   <= '0;
         r_StallCycles <= '0;
      end else if (w_StartAcc) begin
         r_JobCycles   <= '0;
         r_StallCycles <= '0;
      end else begin
         if ((r_State != S_IDLE) && (r_JobCycles != '1)) r_JobCycles <= r_JobCycles + 32'd1;
         if ((r_State == S_STREAM) && i_Vec_Valid && !i_Read && (r_StallCycles != '1))
            r_StallCycles <= r_StallCycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tanimoto_job_ctrl.sv
// Directed-plus-random bench for tanimoto_job_ctrl with a stream-level reference model.
module tb_tanimoto_job_ctrl;
   localparam int BW  = 512;
   localparam int VW  = 920;
   localparam int SVN = 2;
   localparam int RVN = 8;
   localparam int CW  = $clog2(VW);
   localparam int DTO = 16;

   logic          clk = 1'b0;
   logic          rstn;
   logic          i_Start, i_Abort, i_Thr_Valid, o_Thr_Ready;
   logic [31:0]   i_CmpVecNo;
   logic [CW:0]   i_Thr_Data;
   logic [CW-1:0] o_BRAM_Addr;
   logic [CW:0]   o_BRAM_Din;
   logic          o_BRAM_WrEn, i_Vec_Valid, o_Vec_Ready, o_Valid, o_Last, i_Read;
   logic [BW-1:0] i_Vec_Data, o_Vector;
   logic          i_IDPair_Valid, i_IDPair_Read, i_IDPair_Last;
   logic          o_Busy, o_Done, o_Timeout;
   logic [31:0]   o_PairCnt;
`ifdef TANIMOTO_JOB_CTRL_PERF_EN
   logic [31:0]   o_JobCycles, o_StallCycles;
`endif

   always #5 clk = ~clk;

   tanimoto_job_ctrl #(
      .BUS_WIDTH(BW), .VECTOR_WIDTH(VW), .SUB_VECTOR_NO(SVN),
      .REF_VEC_NO(RVN), .CNT_WIDTH(CW), .DRAIN_TIMEOUT(DTO)
   ) dut (
      .clk(clk), .rstn(rstn), .i_Start(i_Start), .i_Abort(i_Abort), .i_CmpVecNo(i_CmpVecNo),
      .i_Thr_Valid(i_Thr_Valid), .i_Thr_Data(i_Thr_Data), .o_Thr_Ready(o_Thr_Ready),
      .o_BRAM_Addr(o_BRAM_Addr), .o_BRAM_Din(o_BRAM_Din), .o_BRAM_WrEn(o_BRAM_WrEn),
      .i_Vec_Valid(i_Vec_Valid), .i_Vec_Data(i_Vec_Data), .o_Vec_Ready(o_Vec_Ready),
      .o_Vector(o_Vector), .o_Valid(o_Valid), .o_Last(o_Last), .i_Read(i_Read),
      .i_IDPair_Valid(i_IDPair_Valid), .i_IDPair_Read(i_IDPair_Read), .i_IDPair_Last(i_IDPair_Last),
      .o_Busy(o_Busy), .o_Done(o_Done), .o_Timeout(o_Timeout),
`ifdef TANIMOTO_JOB_CTRL_PERF_EN
      .o_JobCycles(o_JobCycles), .o_StallCycles(o_StallCycles),
`endif
      .o_PairCnt(o_PairCnt)
   );

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int wr_n, wr_bad, fire_n, last_n, last_bad, last_on_fire, data_bad, valid_seen, stall_n;
   int pair_fires, last_pair_cyc, done_n, done_cyc, start_cyc, thr_ptr, t_words, gap;
   int read_mode, vv_rand, tv_rand, pairs_target, pairs_last, start_noise;
   int thr_val [VW];
   logic [BW-1:0] cur_word;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] rand_word();
      logic [BW-1:0] w;
      for (int i = 0; i < BW/32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // Samples at the falling edge, then returns 1 time unit after the next rising edge.
   task automatic step();
      logic new_word;
      new_word = 1'b0;
      @(negedge clk);
      cyc++;
      if (o_BRAM_WrEn) begin
         if (wr_n >= VW || o_BRAM_Addr != CW'(wr_n) || o_BRAM_Din != (CW+1)'(thr_val[wr_n])) wr_bad++;
         wr_n++;
      end
      if (o_Thr_Ready && i_Thr_Valid) thr_ptr++;
      if (o_Valid) valid_seen++;
      if (o_Valid && !i_Read) stall_n++;
      if (o_Last) begin
         last_n++;
         if (!o_Valid || fire_n != t_words - 1) last_bad++;
      end
      if (o_Vec_Ready) begin
         if (o_Vector !== cur_word) data_bad++;
         if (o_Last) last_on_fire = fire_n;
         fire_n++;
         new_word = 1'b1;
      end
      if (i_IDPair_Valid && i_IDPair_Read) begin
         pair_fires++;
         last_pair_cyc = cyc;
      end
      if (o_Done) begin
         done_n++;
         done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (new_word) cur_word = rand_word();
   endtask

   task automatic drive();
      logic v;
      i_Thr_Valid = (tv_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      i_Thr_Data  = (thr_ptr < VW) ? (CW+1)'(thr_val[thr_ptr]) : '0;
      i_Vec_Data  = cur_word;
      i_Vec_Valid = (vv_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      case (read_mode)
         0:       i_Read = 1'b1;
         1:       i_Read = ~i_Read;
         default: i_Read = 1'($urandom_range(0, 1));
      endcase
      i_Start = (start_noise != 0) && fire_n > 0 && fire_n < t_words && ($urandom_range(0, 3) == 0);
      if (fire_n >= t_words && pair_fires < pairs_target) begin
         v = ($urandom_range(0, 1) == 1) || gap >= 3;
         gap = v ? 0 : gap + 1;
         i_IDPair_Valid = v;
         i_IDPair_Read  = 1'b1;
         i_IDPair_Last  = (pairs_last != 0) && (pair_fires == pairs_target - 1);
      end else begin
         i_IDPair_Valid = 1'b0;
         i_IDPair_Read  = 1'($urandom_range(0, 1));
         i_IDPair_Last  = 1'b0;
      end
   endtask

   task automatic start_job(input int n);
      wr_n = 0; wr_bad = 0; fire_n = 0; last_n = 0; last_bad = 0; last_on_fire = -1;
      data_bad = 0; valid_seen = 0; stall_n = 0; pair_fires = 0; last_pair_cyc = 0;
      done_n = 0; done_cyc = 0; thr_ptr = 0; gap = 0;
      t_words = (RVN + n) * SVN;
      drive();
      i_CmpVecNo = n;
      i_Start    = 1'b1;
      step();
      start_cyc  = cyc;
      i_Start    = 1'b0;
      i_CmpVecNo = $urandom;
   endtask

   task automatic run_to_done(input int budget);
      for (int k = 0; k < budget && done_n == 0; k++) begin
         drive();
         step();
      end
      for (int k = 0; k < 3; k++) begin
         drive();
         step();
      end
   endtask

   task automatic check_job(input int exp_wr, input int exp_fires, input int exp_pairs, input logic exp_to);
      chk("bram_writes", wr_n, exp_wr);
      chk("bram_content", wr_bad, 0);
      chk("word_fires", fire_n, exp_fires);
      chk("last_fire_index", last_on_fire, exp_fires - 1);
      chk("last_misplaced", last_bad, 0);
      chk("vector_data", data_bad, 0);
      chk("done_pulses", done_n, 1);
      chk("pair_cnt", o_PairCnt, exp_pairs);
      chk("timeout_flag", o_Timeout, exp_to);
      chk("idle_after_done", o_Busy, 0);
`ifdef TANIMOTO_JOB_CTRL_PERF_EN
      chk("job_cycles", o_JobCycles, done_cyc - start_cyc);
      chk("stall_cycles", o_StallCycles, stall_n);
`endif
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: observed no end of run, required $finish before 40000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; i_Start = 0; i_Abort = 0; i_CmpVecNo = 0; i_Thr_Valid = 0; i_Thr_Data = '0;
      i_Vec_Valid = 0; i_Read = 0; i_IDPair_Valid = 0; i_IDPair_Read = 0; i_IDPair_Last = 0;
      read_mode = 0; vv_rand = 0; tv_rand = 0; pairs_target = 0; pairs_last = 0; start_noise = 0;
      fire_n = 0; t_words = 0; pair_fires = 0; thr_ptr = 0; gap = 0; done_n = 0;
      for (int i = 0; i < VW; i++) thr_val[i] = i + 1;
      cur_word = rand_word();
      i_Vec_Data = cur_word;

      // Reset state
      step(); step();
      chk("rst_ctrl_outs", {o_Busy, o_Done, o_Thr_Ready, o_BRAM_WrEn, o_Valid, o_Last, o_Vec_Ready, o_Timeout}, 0);
      chk("rst_bram_bus", {o_BRAM_Addr, o_BRAM_Din}, 0);
      chk("rst_pair_cnt", o_PairCnt, 0);
      chk("rst_vector_pass", o_Vector === i_Vec_Data, 1);
      rstn = 1'b1;
      step();

      // Start and abort together in IDLE: abort wins
      i_CmpVecNo = 3; i_Start = 1'b1; i_Abort = 1'b1;
      step();
      i_Start = 1'b0; i_Abort = 1'b0;
      chk("start_abort_idle", o_Busy, 0);

      // Main job: N=128, thr[i]=i+1, 5 pairs with last
      pairs_target = 5; pairs_last = 1;
      start_job(128);
      run_to_done(3000);
      check_job(VW, 272, 5, 1'b0);
      chk("main_last_cycles", last_n, 1);

      // Read toggling 1-0, N=4
      for (int i = 0; i < VW; i++) thr_val[i] = $urandom_range(0, (1 << (CW + 1)) - 1);
      read_mode = 1; pairs_target = 2; pairs_last = 1;
      start_job(4);
      run_to_done(3000);
      check_job(VW, 24, 2, 1'b0);
      read_mode = 0;

      // Drain timeout: 3 pairs, no last flag
      pairs_target = 3; pairs_last = 0;
      start_job(1);
      run_to_done(3000);
      check_job(VW, 18, 3, 1'b1);
      chk("timeout_latency", done_cyc - last_pair_cyc, DTO);

      // N=0: straight to DONE, timeout flag cleared by the start
      pairs_target = 0;
      start_job(0);
      run_to_done(20);
      check_job(0, 0, 0, 1'b0);
      chk("n0_done_latency", (done_cyc - start_cyc) inside {[1:2]}, 1);
      chk("n0_valid_seen", valid_seen, 0);

      // Abort at word 10, then a fresh N=1 job
      start_job(3);
      for (int k = 0; k < 3000 && fire_n < 10; k++) begin
         drive();
         step();
      end
      chk("abort_reached_word10", fire_n, 10);
      drive();
      i_Abort = 1'b1;
      step();
      i_Abort = 1'b0;
      chk("abort_to_idle", o_Busy, 0);
      for (int k = 0; k < 30; k++) begin
         drive();
         step();
      end
      chk("abort_no_done", done_n, 0);
      chk("abort_no_last", last_n, 0);
      pairs_target = 1; pairs_last = 1;
      start_job(1);
      run_to_done(3000);
      check_job(VW, 18, 1, 1'b0);

      // Randomized jobs with busy-time start noise
      tv_rand = 1; vv_rand = 1; read_mode = 2; start_noise = 1;
      for (int j = 0; j < 3; j++) begin
         int n;
         n = $urandom_range(1, 6);
         for (int i = 0; i < VW; i++) thr_val[i] = $urandom_range(0, (1 << (CW + 1)) - 1);
         pairs_target = $urandom_range(0, 4);
         pairs_last   = $urandom_range(0, 1);
         start_job(n);
         run_to_done(8000);
         check_job(VW, (RVN + n) * SVN, pairs_target, !(pairs_last != 0 && pairs_target > 0));
      end
      tv_rand = 0; vv_rand = 0; read_mode = 0; start_noise = 0;

      // Reset in the middle of the threshold load
      pairs_target = 0;
      start_job(5);
      for (int k = 0; k < 1000 && wr_n < 300; k++) begin
         drive();
         step();
      end
      chk("load_reached_300", wr_n, 300);
      rstn = 1'b0;
      #1;
      chk("midrst_ctrl_outs", {o_Busy, o_Done, o_Thr_Ready, o_BRAM_WrEn, o_Valid, o_Last, o_Vec_Ready, o_Timeout}, 0);
      chk("midrst_bram_bus", {o_BRAM_Addr, o_BRAM_Din}, 0);
      chk("midrst_pair_cnt", o_PairCnt, 0);
      drive();
      step();
      rstn = 1'b1;
      drive();
      step();
      chk("postrst_thr_ready", o_Thr_Ready, 0);
      chk("postrst_busy", o_Busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
